// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS fetch/data Avalon bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: arbiter FSM state enum, requester-id type, default timeout.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    localparam int         DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [3:0] FETCH_BYTEENABLE       = 4'b1111;

endpackage

// File: rtl/mips_bus_grant.sv
// Grant selection between instruction fetch and data requesters.
// Latency: combinational grant; last-grant history updates on the accepting edge.
// Backpressure: none; the caller only samples the grant while idle.
//
// Ports: if_req/dm_req requests in; gnt_vld/gnt_id grant out.
// Macro MIPS_BUS_ARB_RR_EN: round-robin on ties, adds clk/reset/grant_take
// ports and the last-grant register. Undefined: data always beats fetch.
module mips_bus_grant
    import mips_bus_pkg::*;
(
`ifdef MIPS_BUS_ARB_RR_EN
    input  logic    clk,
    input  logic    reset,
    input  logic    grant_take,
`endif
    input  logic    if_req,
    input  logic    dm_req,
    output logic    gnt_vld,
    output req_id_t gnt_id
);

    assign gnt_vld = if_req | dm_req;

`ifdef MIPS_BUS_ARB_RR_EN
    // Resets to fetch so that the first tie goes to data.
    req_id_t last_grant;

    always_comb begin
        gnt_id = REQ_IF;
        if (if_req && dm_req) begin
            gnt_id = (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (dm_req) begin
            gnt_id = REQ_DM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_IF;
        end else if (grant_take && gnt_vld) begin
            last_grant <= gnt_id;
        end
    end
`else
    assign gnt_id = dm_req ? REQ_DM : REQ_IF;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates MIPS fetch and data ports onto one Avalon-MM master.
// Latency: req sampled edge 0, bus cycle 1, ack cycle 2 with no waitrequest.
// Backpressure: waitrequest stretches the bus cycle; other requests wait in IDLE.
//
// Ports: clk, reset (async active-low); if_*/dm_* requester side with one-cycle
// acks and held rdata; Avalon master address/read/write/writedata/byteenable/
// waitrequest/readdata; sticky bus_timeout. Macro MIPS_BUS_ARB_RR_EN selects
// round-robin tie breaking instead of data-first fixed priority.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic        dm_write,
    input  logic [31:0] dm_writedata,
    input  logic [3:0]  dm_byteenable,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        bus_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    req_id_t          gnt;
    req_id_t          gnt_id;
    logic             gnt_vld;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;

    mips_bus_grant u_grant (
`ifdef MIPS_BUS_ARB_RR_EN
        .clk        (clk),
        .reset      (reset),
        .grant_take (state == IDLE),
`endif
        .if_req     (if_req),
        .dm_req     (dm_req),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    // Saturating so a hung slave cannot wrap the counter back under the limit.
    assign wait_cnt_nxt = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gnt         <= REQ_IF;
            address     <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            writedata   <= '0;
            byteenable  <= '0;
            if_ack      <= 1'b0;
            dm_ack      <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            wait_cnt    <= '0;
            bus_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        gnt      <= gnt_id;
                        wait_cnt <= '0;
                        state    <= BUS;
                        if (gnt_id == REQ_DM) begin
                            address    <= dm_addr;
                            read       <= ~dm_write;
                            write      <= dm_write;
                            writedata  <= dm_write ? dm_writedata : '0;
                            byteenable <= dm_byteenable;
                        end else begin
                            address    <= if_addr;
                            read       <= 1'b1;
                            write      <= 1'b0;
                            writedata  <= '0;
                            byteenable <= FETCH_BYTEENABLE;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        state <= RESP;
                        // Writes complete without touching the held rdata.
                        if (gnt == REQ_DM) begin
                            dm_ack <= 1'b1;
                            if (read) dm_rdata <= readdata;
                        end else begin
                            if_ack <= 1'b1;
                            if (read) if_rdata <= readdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                        // Flag only; the transfer is still allowed to finish.
                        if (wait_cnt_nxt >= TIMEOUT_LIM) bus_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: waitrequest driven directly by the bench.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic [31:0] dm_addr = '0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_writedata = '0;
    logic [3:0]  dm_byteenable = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        bus_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .if_rdata      (if_rdata),
        .dm_req        (dm_req),
        .dm_addr       (dm_addr),
        .dm_write      (dm_write),
        .dm_writedata  (dm_writedata),
        .dm_byteenable (dm_byteenable),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .bus_timeout   (bus_timeout)
    );

    typedef struct {
        logic        if_req;
        logic        dm_req;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic        dm_write;
        logic [31:0] dm_wd;
        logic [3:0]  dm_be;
        logic [31:0] bus_rd;
        logic        exp_dm;
        logic [31:0] exp_addr;
        logic        exp_read;
        logic        exp_write;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_word;
        logic        exp_seq [4];

        //            ifr  dmr  if_addr       dm_addr       dw   dm_wd         be       bus_rd        dm   addr          rd   wr   wd            be       rdata
        vecs[0] = '{1'b1, 1'b0, 32'hBFC00000, 32'h00000000, 1'b0, 32'h0,        4'b0000, 32'h8C080004, 1'b0, 32'hBFC00000, 1'b1, 1'b0, 32'h0,        4'b1111, 32'h8C080004};
        vecs[1] = '{1'b0, 1'b1, 32'h00000000, 32'h10010000, 1'b0, 32'hDEADBEEF, 4'b0001, 32'h000000AB, 1'b1, 32'h10010000, 1'b1, 1'b0, 32'h0,        4'b0001, 32'h000000AB};
        vecs[2] = '{1'b0, 1'b1, 32'h00000000, 32'h10010004, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h55555555, 1'b1, 32'h10010004, 1'b0, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h000000AB};
        vecs[3] = '{1'b1, 1'b0, 32'h00400020, 32'h00000000, 1'b0, 32'h0,        4'b0010, 32'h24020001, 1'b0, 32'h00400020, 1'b1, 1'b0, 32'h0,        4'b1111, 32'h24020001};
        vecs[4] = '{1'b0, 1'b1, 32'h00000000, 32'h10010008, 1'b1, 32'h0BADBEEF, 4'b1100, 32'h00000077, 1'b1, 32'h10010008, 1'b0, 1'b1, 32'h0BADBEEF, 4'b1100, 32'h000000AB};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_acks", {if_ack, dm_ack}, 0);
        chk("rst_timeout", bus_timeout, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_byteenable", byteenable, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        reset = 1'b1;
        tick();

        // ---------------- single-requester vectors ----------------
        for (int i = 0; i < 5; i++) begin
            if_req        = vecs[i].if_req;
            dm_req        = vecs[i].dm_req;
            if_addr       = vecs[i].if_addr;
            dm_addr       = vecs[i].dm_addr;
            dm_write      = vecs[i].dm_write;
            dm_writedata  = vecs[i].dm_wd;
            dm_byteenable = vecs[i].dm_be;
            readdata      = vecs[i].bus_rd;
            waitrequest   = 1'b0;
            tick();
            chk($sformatf("v%0d_read", i), read, vecs[i].exp_read);
            chk($sformatf("v%0d_write", i), write, vecs[i].exp_write);
            chk($sformatf("v%0d_address", i), address, vecs[i].exp_addr);
            chk($sformatf("v%0d_writedata", i), writedata, vecs[i].exp_wd);
            chk($sformatf("v%0d_byteenable", i), byteenable, vecs[i].exp_be);
            tick();
            if (vecs[i].exp_dm) begin
                chk($sformatf("v%0d_dm_ack", i), dm_ack, 1);
                chk($sformatf("v%0d_if_ack", i), if_ack, 0);
                chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].exp_rdata);
            end else begin
                chk($sformatf("v%0d_if_ack", i), if_ack, 1);
                chk($sformatf("v%0d_dm_ack", i), dm_ack, 0);
                chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_rdata);
            end
            chk($sformatf("v%0d_resp_rw", i), {read, write}, 0);
            if_req = 1'b0;
            dm_req = 1'b0;
            tick();
            chk($sformatf("v%0d_ack_drop", i), {if_ack, dm_ack}, 0);
        end

        // ---------------- simultaneous requests, both held ----------------
`ifdef MIPS_BUS_ARB_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        if_addr  = 32'h00400100;
        dm_addr  = 32'h10020000;
        dm_write = 1'b0;
        dm_byteenable = 4'b1111;
        if_req   = 1'b1;
        dm_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_word  = 32'h00001000 + k;
            readdata = rd_word;
            tick();
            chk($sformatf("tie%0d_address", k), address, exp_seq[k] ? 32'h10020000 : 32'h00400100);
            chk($sformatf("tie%0d_read", k), read, 1);
            tick();
            chk($sformatf("tie%0d_acks", k), {if_ack, dm_ack}, exp_seq[k] ? 2'b01 : 2'b10);
            chk($sformatf("tie%0d_rdata", k), exp_seq[k] ? dm_rdata : if_rdata, rd_word);
            tick();
        end
        dm_req   = 1'b0;
        readdata = 32'h0000BEEF;
        tick();
        chk("tie_last_address", address, 32'h00400100);
        tick();
        chk("tie_last_if_ack", if_ack, 1);
        chk("tie_last_if_rdata", if_rdata, 32'h0000BEEF);
        if_req = 1'b0;
        tick();

        // ---------------- write with 3 wait cycles ----------------
        rd_word       = dm_rdata;
        dm_req        = 1'b1;
        dm_addr       = 32'h10010010;
        dm_write      = 1'b1;
        dm_writedata  = 32'h12345678;
        dm_byteenable = 4'b0011;
        waitrequest   = 1'b1;
        readdata      = 32'hFFFFFFFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("ws%0d_write", c), write, 1);
            chk($sformatf("ws%0d_address", c), address, 32'h10010010);
            chk($sformatf("ws%0d_writedata", c), writedata, 32'h12345678);
            chk($sformatf("ws%0d_byteenable", c), byteenable, 4'b0011);
            chk($sformatf("ws%0d_ack", c), dm_ack, 0);
            if (c == 3) waitrequest = 1'b0;
        end
        tick();
        chk("ws_dm_ack", dm_ack, 1);
        chk("ws_write_drop", write, 0);
        chk("ws_dm_rdata_kept", dm_rdata, rd_word);
        dm_req = 1'b0;
        tick();
        chk("ws_ack_once", dm_ack, 0);
        chk("ws_no_timeout", bus_timeout, 0);

        // ---------------- timeout after 4 wait cycles ----------------
        if_req      = 1'b1;
        if_addr     = 32'h00400200;
        waitrequest = 1'b1;
        readdata    = 32'h3C1D1001;
        tick();
        for (int w = 1; w <= 6; w++) begin
            tick();
            chk($sformatf("to%0d_timeout", w), bus_timeout, (w >= 4) ? 1 : 0);
            if (w == 6) waitrequest = 1'b0;
        end
        tick();
        chk("to_if_ack", if_ack, 1);
        chk("to_if_rdata", if_rdata, 32'h3C1D1001);
        if_req = 1'b0;
        repeat (3) tick();
        chk("to_sticky", bus_timeout, 1);

        // ---------------- reset mid-BUS ----------------
        dm_req      = 1'b1;
        dm_addr     = 32'h10030000;
        dm_write    = 1'b0;
        waitrequest = 1'b1;
        tick();
        chk("rb_read_before", read, 1);
        #2;
        reset  = 1'b0;
        dm_req = 1'b0;
        #1;
        chk("rb_async_rw", {read, write}, 0);
        chk("rb_timeout_clr", bus_timeout, 0);
        tick();
        chk("rb_no_ack", {if_ack, dm_ack}, 0);
        reset       = 1'b1;
        waitrequest = 1'b0;
        if_req      = 1'b1;
        if_addr     = 32'hBFC00000;
        readdata    = 32'h10000003;
        tick();
        chk("rb_post_read", read, 1);
        chk("rb_post_address", address, 32'hBFC00000);
        tick();
        chk("rb_post_if_ack", if_ack, 1);
        chk("rb_post_if_rdata", if_rdata, 32'h10000003);
        chk("rb_post_dm_rdata", dm_rdata, 0);
        if_req = 1'b0;
        tick();
        chk("rb_post_ack_drop", if_ack, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, waitrequest cycles per transfer before the timeout flag is set.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset: asserted when low, asserts without clk, released synchronously to clk.
REQ-004 SHALL have ports if_req/dm_req  in  1  fetch/data requester asks for a transfer.
REQ-005 SHALL have ports if_addr/dm_addr  in  32  requester byte address.
REQ-006 SHALL have port dm_write  in  1  data transfer is write (fetch is always read); dm_writedata  in  32; dm_byteenable  in  4.
REQ-007 SHALL have ports if_ack/dm_ack  out  1  one-cycle completion pulse; if_rdata/dm_rdata  out  32  read data, valid while ack high.
REQ-008 SHALL have Avalon master ports address out 32, read out 1, write out 1, writedata out 32, byteenable out 4, waitrequest in 1, readdata in 32.
REQ-009 SHALL have port bus_timeout  out  1  sticky timeout flag.

Function
REQ-010 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE.
REQ-011 IDLE: if any req high at edge, SHALL grant one, register its address/write/writedata/byteenable, go BUS; else stay IDLE.
REQ-012 Fixed priority: data beats fetch when both request in the same cycle.
REQ-013 BUS: read or write high (exactly one), all Avalon outputs from registers, stable until completion.
REQ-014 Completion = edge with read|write high and waitrequest low; SHALL capture readdata into the granted requester's rdata, go RESP.
REQ-015 RESP: granted requester's ack high exactly one cycle; other ack low; no Avalon read/write; next state IDLE unconditionally.
REQ-016 Minimum latency: req sampled edge 0, bus cycle 1, ack cycle 2 (waitrequest low).
REQ-017 Requester SHALL hold req and fields stable until ack; req still high at the edge ending RESP is a new request.
REQ-018 Requests arriving in BUS/RESP SHALL wait; the in-flight grant is never preempted.
REQ-019 Byteenable forced to 4'b1111 for fetch; writedata value don't-care on reads but registered deterministically (zero).
REQ-020 Wait counter (8 bits min, saturating) clears on grant, increments each BUS cycle with waitrequest high; reaching TIMEOUT_CYCLES sets bus_timeout; the transfer still continues to completion.
REQ-021 rdata outputs SHALL hold last captured value between acks; write completion leaves rdata unchanged.

Reset
REQ-022 Reset SHALL force IDLE; read, write, both acks, bus_timeout = 0; address, writedata, rdata = 0; byteenable = 0; counter = 0.
REQ-023 Reset mid-BUS SHALL abandon the transfer with no ack; first grant after release obeys REQ-011.
REQ-024 bus_timeout cleared only by reset.

Configuration
REQ-025 Macro MIPS_BUS_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted most recently wins; last-grant register resets to fetch (so data wins first tie).
REQ-026 Macro undefined: fixed priority per REQ-012; no last-grant register.

Structure
REQ-027 Package mips_bus_pkg SHALL hold FSM state enum (IDLE/BUS/RESP), requester-id typedef (REQ_IF/REQ_DM), and default timeout constant.
REQ-028 Sub-module mips_bus_grant SHALL compute the grant from the two reqs and, under MIPS_BUS_ARB_RR_EN, own the last-grant register.

Verification
REQ-029 Fetch alone, if_addr=0xBFC00000, waitrequest low -> read high cycle 1 with address 0xBFC00000, if_ack cycle 2, if_rdata=readdata.
REQ-030 Both req same cycle, fixed priority -> dm serviced first, if serviced after dm_ack; RR build twice -> grants alternate dm, if, dm, if.
REQ-031 dm write 0x12345678 byteenable 4'b0011, waitrequest high 3 cycles -> write/address/writedata stable 4 cycles, dm_ack once, dm_rdata unchanged.
REQ-032 TIMEOUT_CYCLES=4, waitrequest high 6 cycles -> bus_timeout rises after 4th wait cycle, stays high after ack until reset.
REQ-033 Reset low during BUS -> read/write drop immediately (asynchronously), no ack; after release if_req -> normal 2-cycle transfer.
